// File: rtl/led_sequencer.sv
// LED sequencer: the CPU writes a pattern and a control word, and this block
// then drives the 10-LED output register through led_in/led_load without any
// further CPU writes. The sequences are static, blink, rotating chase, and
// bouncing single LED. Steps occur every TICK_DIV*(P+1) clk.
module led_sequencer #(
  parameter int TICK_DIV = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        addr,
  input  logic        load,
  output logic [15:0] out,
  output logic [15:0] led_in,
  output logic        led_load
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_DIRECT,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_CHASE,
    S_BOUNCE
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      pattern_q, pattern_d;
  logic [9:0]      ctrl_q, ctrl_d;
  logic [9:0]      frame_q, frame_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      step_q, step_d;
  logic [3:0]      pos_q, pos_d;
  logic            dir_q, dir_d;     // 1 = moving up
  logic            led_load_q, led_load_d;

  logic            tick;
  logic            step_evt;
  logic [3:0]      pos_nx;
  logic [7:0]      period;
  logic            unused_hi;

  assign period    = ctrl_q[9:2];
  assign unused_hi = ^in[15:10];

  // Readback and LED-register drive
  assign out      = addr ? {6'b0, ctrl_q} : {6'b0, pattern_q};
  assign led_in   = {6'b0, frame_q};
  assign led_load = led_load_q;

  // Next state: timers, CPU writes (which take priority), then step actions
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    ctrl_d     = ctrl_q;
    frame_d    = frame_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    led_load_d = 1'b0;
    pos_nx     = dir_q ? pos_q + 4'd1 : pos_q - 4'd1;

    tick     = (presc_q == PRESC_MAX);
    presc_d  = tick ? '0 : presc_q + PW'(1);
    step_d   = step_q;
    if (tick) begin
      step_d = (step_q == period) ? 8'd0 : step_q + 8'd1;
    end
    step_evt = tick && (step_q == period) && (state_q != S_DIRECT);

    if (load && addr) begin
      ctrl_d     = in[9:0];
      presc_d    = '0;
      step_d     = 8'd0;
      led_load_d = 1'b1;
      case (in[1:0])
        2'b00: begin
          state_d = S_DIRECT;
          frame_d = pattern_q;
        end
        2'b01: begin
          state_d = S_BLINK_ON;
          frame_d = pattern_q;
        end
        2'b10: begin
          state_d = S_CHASE;
          frame_d = (pattern_q == 10'd0) ? 10'd1 : pattern_q;
        end
        default: begin
          state_d = S_BOUNCE;
          pos_d   = 4'd0;
          dir_d   = 1'b1;
          frame_d = 10'd1;
        end
      endcase
    end else if (load) begin
      // A pattern write also swallows any coincident step action.
      pattern_d = in[9:0];
      if (state_q == S_DIRECT || state_q == S_BLINK_ON) begin
        frame_d    = in[9:0];
        led_load_d = 1'b1;
      end
    end else if (step_evt) begin
      led_load_d = 1'b1;
      case (state_q)
        S_BLINK_ON: begin
          state_d = S_BLINK_OFF;
          frame_d = 10'd0;
        end
        S_BLINK_OFF: begin
          state_d = S_BLINK_ON;
          frame_d = pattern_q;
        end
        S_CHASE: begin
          frame_d = {frame_q[8:0], frame_q[9]};
        end
        S_BOUNCE: begin
          pos_d   = pos_nx;
          frame_d = 10'd1 << pos_nx;
          if (pos_nx == 4'd9) dir_d = 1'b0;
          if (pos_nx == 4'd0) dir_d = 1'b1;
        end
        default: led_load_d = 1'b0;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_DIRECT;
      pattern_q  <= 10'd0;
      ctrl_q     <= 10'd0;
      frame_q    <= 10'd0;
      presc_q    <= '0;
      step_q     <= 8'd0;
      pos_q      <= 4'd0;
      dir_q      <= 1'b1;
      led_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      ctrl_q     <= ctrl_d;
      frame_q    <= frame_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      led_load_q <= led_load_d;
    end
  end

endmodule
